// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions used by the IF/ID pipeline register.
//   - PC_INIT     : PC value presented for a bubble or after reset
//   - NOP_WORD    : instruction word substituted for a bubble or a faulted fetch
//   - EXC_NONE    : exception code meaning "no exception"
//   - EXC_ADEL    : address error on load/fetch
//   - IM_LO/IM_HI : lowest and highest legal instruction-fetch addresses
//   - id_stage_t  : the contents of the ID stage, with a bubble constructor
package cpu_defs_pkg;

  localparam logic [31:0] PC_INIT  = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [31:0] IM_LO    = 32'h0000_3000;
  localparam logic [31:0] IM_HI    = 32'h0000_6FFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        bd;
    logic [4:0]  exc_code;
  } id_stage_t;

  // An empty slot: no instruction, no delay slot, no exception.
  function automatic id_stage_t make_bubble(input logic [31:0] pc);
    id_stage_t b;
    b.pc       = pc;
    b.instr    = NOP_WORD;
    b.valid    = 1'b0;
    b.bd       = 1'b0;
    b.exc_code = EXC_NONE;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg_if.sv
// Bus between the fetch stage, the hazard unit and the decode stage,
// as seen by the IF/ID pipeline register.
//   Control : stall, flush
//   IF side : if_pc[31:0], if_instr[31:0], if_bd
//   ID side : id_pc[31:0], id_instr[31:0], id_valid, id_bd,
//             id_exc_code[4:0], id_stall_cnt[15:0]
// Modports:
//   master : drives control and IF side, observes ID side
//   slave  : the pipeline register itself
interface if_id_reg_if;

  logic        stall;
  logic        flush;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_bd;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        id_bd;
  logic [4:0]  id_exc_code;
  logic [15:0] id_stall_cnt;

  modport master (
    output stall, flush, if_pc, if_instr, if_bd,
    input  id_pc, id_instr, id_valid, id_bd, id_exc_code, id_stall_cnt
  );

  modport slave (
    input  stall, flush, if_pc, if_instr, if_bd,
    output id_pc, id_instr, id_valid, id_bd, id_exc_code, id_stall_cnt
  );

endinterface

// File: rtl/if_exc_chk.sv
// Combinational fetch-address checker.
//   if_pc[31:0]   in  : fetch address
//   exc_code[4:0] out : EXC_ADEL when the address is misaligned or outside
//                       [IM_LO, IM_HI] (bounds inclusive, unsigned), else EXC_NONE
// Only compiled when IF_EXC_CHECK_EN is defined; the build without the
// check has no use for it.
`ifdef IF_EXC_CHECK_EN
module if_exc_chk #(
  parameter logic [31:0] IM_LO = cpu_defs_pkg::IM_LO,
  parameter logic [31:0] IM_HI = cpu_defs_pkg::IM_HI
) (
  input  logic [31:0] if_pc,
  output logic [4:0]  exc_code
);
  import cpu_defs_pkg::*;

  logic misaligned;
  logic below;
  logic above;

  always_comb begin
    misaligned = (if_pc[1:0] != 2'b00);
    below      = (if_pc < IM_LO);
    above      = (if_pc > IM_HI);
    exc_code   = (misaligned || below || above) ? EXC_ADEL : EXC_NONE;
  end

endmodule
`endif

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   bus   : if_id_reg_if.slave (stall/flush, IF inputs, ID outputs)
// Per-edge priority: reset > flush > stall > load.
// id_stall_cnt counts edges with stall=1, flush=0, reset=0 and saturates at 16'hFFFF.
// Build option: define IF_EXC_CHECK_EN to check fetch addresses; a faulted
// fetch loads a NOP with id_exc_code = AdEL. Without it id_exc_code stays 0.
module if_id_reg #(
  parameter logic [31:0] PC_INIT = cpu_defs_pkg::PC_INIT,
  parameter logic [31:0] IM_LO   = cpu_defs_pkg::IM_LO,
  parameter logic [31:0] IM_HI   = cpu_defs_pkg::IM_HI
) (
  input  logic         clk,
  input  logic         reset,
  if_id_reg_if.slave   bus
);
  import cpu_defs_pkg::*;

  id_stage_t   stage_q, stage_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [4:0]  fetch_exc;

`ifdef IF_EXC_CHECK_EN
  if_exc_chk #(
    .IM_LO (IM_LO),
    .IM_HI (IM_HI)
  ) u_if_exc_chk (
    .if_pc    (bus.if_pc),
    .exc_code (fetch_exc)
  );
`else
  logic unused_bounds;
  assign unused_bounds = ^{IM_LO, IM_HI};
  assign fetch_exc     = EXC_NONE;
`endif

  always_comb begin
    stage_d     = stage_q;
    stall_cnt_d = stall_cnt_q;
    if (reset) begin
      stage_d     = make_bubble(PC_INIT);
      stall_cnt_d = '0;
    end else if (bus.flush) begin
      stage_d = make_bubble(PC_INIT);
    end else if (bus.stall) begin
      if (stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end else begin
      stage_d.pc       = bus.if_pc;
      stage_d.valid    = 1'b1;
      stage_d.bd       = bus.if_bd;
      stage_d.exc_code = fetch_exc;
      // A faulted fetch never reaches decode as a real opcode.
      stage_d.instr    = (fetch_exc != EXC_NONE) ? NOP_WORD : bus.if_instr;
    end
  end

  always_ff @(posedge clk) begin
    stage_q     <= stage_d;
    stall_cnt_q <= stall_cnt_d;
  end

  assign bus.id_pc        = stage_q.pc;
  assign bus.id_instr     = stage_q.instr;
  assign bus.id_valid     = stage_q.valid;
  assign bus.id_bd        = stage_q.bd;
  assign bus.id_exc_code  = stage_q.exc_code;
  assign bus.id_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed scenarios with literal
// expectations, then randomized traffic and a long stall run, all compared
// every cycle against a behavioural model of the ID stage.
module tb_if_id_reg;

  localparam logic [31:0] M_PC_INIT = 32'h0000_3000;
  localparam logic [31:0] M_IM_LO   = 32'h0000_3000;
  localparam logic [31:0] M_IM_HI   = 32'h0000_6FFC;

  logic clk = 1'b0;
  logic reset;
  if_id_reg_if bus ();

  if_id_reg #(
    .PC_INIT (32'h0000_3000),
    .IM_LO   (32'h0000_3000),
    .IM_HI   (32'h0000_6FFC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Model state: what the ID stage must hold after each edge.
  logic [31:0] m_pc, m_instr;
  logic        m_valid, m_bd;
  logic [4:0]  m_exc;
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit fetch_fault(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc < M_IM_LO) || (pc > M_IM_HI);
  endfunction

  always @(posedge clk) begin
    if (reset || bus.flush) begin
      m_pc = M_PC_INIT; m_instr = 32'h0; m_valid = 1'b0; m_bd = 1'b0; m_exc = 5'd0;
      if (reset) m_cnt = 0;
    end else if (bus.stall) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else begin
      m_pc = bus.if_pc; m_bd = bus.if_bd; m_valid = 1'b1;
`ifdef IF_EXC_CHECK_EN
      if (fetch_fault(bus.if_pc)) begin
        m_exc = 5'd4; m_instr = 32'h0;
      end else begin
        m_exc = 5'd0; m_instr = bus.if_instr;
      end
`else
      m_exc = 5'd0; m_instr = bus.if_instr;
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model id_pc",        bus.id_pc,                m_pc);
      check("model id_instr",     bus.id_instr,             m_instr);
      check("model id_valid",     {31'b0, bus.id_valid},    {31'b0, m_valid});
      check("model id_bd",        {31'b0, bus.id_bd},       {31'b0, m_bd});
      check("model id_exc_code",  {27'b0, bus.id_exc_code}, {27'b0, m_exc});
      check("model id_stall_cnt", {16'b0, bus.id_stall_cnt}, m_cnt[31:0]);
    end
  end

  task automatic step(input logic r, input logic s, input logic f,
                      input logic [31:0] pc, input logic [31:0] instr, input logic bd);
    reset        = r;
    bus.stall    = s;
    bus.flush    = f;
    bus.if_pc    = pc;
    bus.if_instr = instr;
    bus.if_bd    = bd;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] base;
    case ($urandom_range(0, 7))
      0: rand_pc = 32'h0000_3000;
      1: rand_pc = 32'h0000_6FFC;
      2: rand_pc = 32'h0000_2FFC;
      3: rand_pc = 32'h0000_7000;
      4: begin base = 32'h3000 + ($urandom_range(0, 16'h3FFF) << 2); rand_pc = base | 32'($urandom_range(1, 3)); end
      5: rand_pc = $urandom;
      default: rand_pc = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
    endcase
  endfunction

  logic [31:0] frozen_pc;

  initial begin
    reset = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.if_pc = 32'h3004; bus.if_instr = 32'hDEAD_BEEF; bus.if_bd = 1'b0;

    // Reset for two cycles, even with a fetch PC presented.
    step(1, 0, 0, 32'h3004, 32'hDEAD_BEEF, 0);
    chk_en = 1'b1;
    step(1, 1, 1, 32'h3004, 32'hDEAD_BEEF, 1);
    check("reset id_pc",        bus.id_pc, 32'h3000);
    check("reset id_valid",     {31'b0, bus.id_valid}, 32'd0);
    check("reset id_stall_cnt", {16'b0, bus.id_stall_cnt}, 32'd0);

    // First edge after reset loads normally.
    step(0, 0, 0, 32'h3008, 32'h3C01_1234, 1);
    check("load id_pc",    bus.id_pc, 32'h3008);
    check("load id_instr", bus.id_instr, 32'h3C01_1234);
    check("load id_bd",    {31'b0, bus.id_bd}, 32'd1);
    check("load id_valid", {31'b0, bus.id_valid}, 32'd1);

    // Stall three cycles while the fetch side keeps moving.
    step(0, 1, 0, 32'h300C, 32'h1111_1111, 0);
    step(0, 1, 0, 32'h3010, 32'h2222_2222, 0);
    step(0, 1, 0, 32'h3014, 32'h3333_3333, 0);
    check("stall id_pc",     bus.id_pc, 32'h3008);
    check("stall id_instr",  bus.id_instr, 32'h3C01_1234);
    check("stall id_bd",     {31'b0, bus.id_bd}, 32'd1);
    check("stall count",     {16'b0, bus.id_stall_cnt}, 32'd3);

    // Flush together with stall gives a bubble and does not count.
    step(0, 1, 1, 32'h3018, 32'h4444_4444, 1);
    check("flush id_valid",  {31'b0, bus.id_valid}, 32'd0);
    check("flush id_instr",  bus.id_instr, 32'h0);
    check("flush id_pc",     bus.id_pc, 32'h3000);
    check("flush count",     {16'b0, bus.id_stall_cnt}, 32'd3);

    // Fetch-address boundaries.
    step(0, 0, 0, 32'h3002, 32'h5555_5555, 0);
`ifdef IF_EXC_CHECK_EN
    check("misaligned exc",   {27'b0, bus.id_exc_code}, 32'd4);
    check("misaligned instr", bus.id_instr, 32'h0);
`else
    check("misaligned exc",   {27'b0, bus.id_exc_code}, 32'd0);
    check("misaligned instr", bus.id_instr, 32'h5555_5555);
`endif
    check("misaligned pc",    bus.id_pc, 32'h3002);
    check("misaligned valid", {31'b0, bus.id_valid}, 32'd1);
    step(0, 0, 0, 32'h7000, 32'h6666_6666, 0);
`ifdef IF_EXC_CHECK_EN
    check("above hi exc", {27'b0, bus.id_exc_code}, 32'd4);
`else
    check("above hi exc", {27'b0, bus.id_exc_code}, 32'd0);
`endif
    step(0, 0, 0, 32'h6FFC, 32'h7777_7777, 0);
    check("at hi exc",   {27'b0, bus.id_exc_code}, 32'd0);
    check("at hi instr", bus.id_instr, 32'h7777_7777);
    step(0, 0, 0, 32'h3000, 32'h8888_8888, 1);
    check("at lo exc",   {27'b0, bus.id_exc_code}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 10),
           rand_pc(), $urandom, 1'($urandom_range(0, 1)));
    end

    // Long stall run to reach saturation.
    step(1, 0, 0, 32'h3000, 32'h0, 0);
    step(0, 0, 0, 32'h3020, 32'h9999_9999, 0);
    frozen_pc = bus.id_pc;
    for (int i = 0; i < 65534; i++) begin
      step(0, 1, 0, 32'h3024 + 32'(i % 16) * 4, $urandom, 0);
    end
    check("pre-sat count", {16'b0, bus.id_stall_cnt}, 32'h0000_FFFE);
    step(0, 1, 0, 32'h3100, 32'h0, 0);
    check("sat count 1", {16'b0, bus.id_stall_cnt}, 32'h0000_FFFF);
    step(0, 1, 0, 32'h3104, 32'h0, 0);
    step(0, 1, 0, 32'h3108, 32'h0, 0);
    check("sat count hold", {16'b0, bus.id_stall_cnt}, 32'h0000_FFFF);
    check("sat frozen pc",  bus.id_pc, 32'h3020);
    step(0, 0, 0, 32'h310C, 32'hABCD_0001, 0);
    check("sat after load", {16'b0, bus.id_stall_cnt}, 32'h0000_FFFF);
    check("sat load pc",    bus.id_pc, 32'h310C);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 Parameter PC_INIT, default 32'h0000_3000, is the bubble/reset PC value presented downstream.
REQ-002 Parameter IM_LO, default 32'h0000_3000, is the lowest legal fetch address.
REQ-003 Parameter IM_HI, default 32'h0000_6FFC, is the highest legal fetch address.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 stall  input  1  hold all ID outputs this cycle.
REQ-007 flush  input  1  replace the ID contents with a bubble this cycle.
REQ-008 if_pc  input  32  PC of the instruction being fetched, from the PC register.
REQ-009 if_instr  input  32  instruction word read from instruction memory at if_pc.
REQ-010 if_bd  input  1  fetched instruction sits in a branch delay slot.
REQ-011 id_pc  output  32  registered PC for the decode stage.
REQ-012 id_instr  output  32  registered instruction for decode.
REQ-013 id_valid  output  1  1 = real instruction, 0 = bubble.
REQ-014 id_bd  output  1  registered delay-slot flag.
REQ-015 id_exc_code  output  5  registered fetch exception code; 0 = none.
REQ-016 id_stall_cnt  output  16  saturating count of stalled cycles since reset.

Function
REQ-017 Per-edge priority SHALL be reset > flush > stall > load.
REQ-018 Load: id_pc<=if_pc, id_instr<=if_instr, id_bd<=if_bd, id_valid<=1, id_exc_code<=checked code; latency exactly 1 cycle.
REQ-019 Stall (flush=0): every ID output SHALL hold its value.
REQ-020 Flush: id_pc<=PC_INIT, id_instr<=0, id_valid<=0, id_bd<=0, id_exc_code<=0.
REQ-021 Flush asserted together with stall SHALL produce a bubble (flush wins).
REQ-022 id_stall_cnt SHALL increment on every edge with stall=1 and flush=0 and reset=0.
REQ-023 id_stall_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-024 Fetch check: if_pc[1:0]!=0, if_pc<IM_LO, or if_pc>IM_HI SHALL be a fetch fault.
REQ-025 On a loaded fetch fault: id_exc_code<=5'd4 (AdEL), id_instr<=0, id_pc<=if_pc, id_valid<=1.
REQ-026 All address comparisons SHALL be unsigned 32-bit; boundaries IM_LO and IM_HI themselves are legal.

Reset
REQ-027 On reset: id_pc=PC_INIT, id_instr=0, id_valid=0, id_bd=0, id_exc_code=0, id_stall_cnt=0.
REQ-028 Reset asserted while stall or flush is active SHALL override both.
REQ-029 The first rising edge after reset deasserts with stall=0 SHALL load normally.

Configuration
REQ-030 Macro IF_EXC_CHECK_EN SHALL compile the fetch check of REQ-024 to REQ-026.
REQ-031 With IF_EXC_CHECK_EN defined: REQ-024 to REQ-026 apply.
REQ-032 Without IF_EXC_CHECK_EN: id_exc_code is constant 0 and if_instr passes unmodified for every address.
REQ-033 The port list SHALL be identical in both builds.

Structure
REQ-034 Shared package cpu_defs_pkg SHALL hold PC_INIT, the NOP word 32'h0, EXC_NONE=5'd0, EXC_ADEL=5'd4, and the IM address bounds.
REQ-035 The fetch check SHALL be a combinational sub-module if_exc_chk (if_pc in, 5-bit code out).
REQ-036 if_exc_chk SHALL be instantiated only under IF_EXC_CHECK_EN.

Verification
REQ-037 Reset high 2 cycles, if_pc=32'h3004 -> id_pc=32'h3000, id_valid=0, id_stall_cnt=0.
REQ-038 Load if_pc=32'h3008, if_instr=32'h3C01_1234, if_bd=1 -> next cycle id_pc=32'h3008, id_instr=32'h3C01_1234, id_bd=1, id_valid=1.
REQ-039 Stall 3 cycles while if_pc changes -> ID outputs frozen; id_stall_cnt=3.
REQ-040 stall=1 and flush=1 together -> bubble (id_valid=0, id_instr=0); id_stall_cnt unchanged.
REQ-041 IF_EXC_CHECK_EN defined: if_pc=32'h3002 -> id_exc_code=4, id_instr=0. if_pc=32'h7000 -> id_exc_code=4. if_pc=32'h6FFC -> id_exc_code=0.
REQ-042 Force id_stall_cnt to 16'hFFFE, then stall 3 cycles -> count reaches 16'hFFFF and holds.
